// File: rtl/demux18_pkg.sv
// Shared types and defaults for the demux18 deserializer.
package demux18_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } dmx_state_t;

endpackage

// File: rtl/demux18_deser_sel_counter.sv
// Mod-N up counter that selects the next slot in auto mode.
module sel_counter #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [SW-1:0] cnt_o
);

  logic [SW-1:0] cnt_q, cnt_d;

  // clr wins over en so the final auto write of a word leaves the count at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == SW'(N - 1)) ? '0 : cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux18_deser.sv
// 1-to-N demultiplexing deserializer: steers serial bits into slots and
// emits the assembled word on a valid/ready output.
module demux18_deser
  import demux18_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          sel_mode,
  input  logic [SW-1:0] sel_ext,
  input  logic          clr,
  output logic [N-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [SW-1:0] sel_cur,
  output logic          dup,
  output dmx_state_t    dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // din_ready is registered; dout holds steady while dout_valid && !dout_ready.

  dmx_state_t    state_q, state_d;
  logic          mode_q;
  logic [N-1:0]  shadow_q, shadow_d, mask_q, mask_d, dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          din_ready_q, dup_q, dup_d;
  logic [SW-1:0] last_q, last_d, cnt, slot;
  logic [N-1:0]  shadow_wr, mask_wr;
  logic          mode_eff, accept, cnt_en, cnt_clr;

  sel_counter #(.N(N)) u_sel_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .cnt_o (cnt)
  );

  // In IDLE the live sel_mode governs the first bit; mid-word the latched copy does.
  assign mode_eff = (state_q == IDLE) ? sel_mode : mode_q;
  assign accept   = din_valid && din_ready_q;
  assign slot     = mode_eff ? sel_ext : cnt;

  always_comb begin
    shadow_wr       = shadow_q;
    shadow_wr[slot] = din;
    mask_wr         = mask_q;
    mask_wr[slot]   = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    mask_d       = mask_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    dup_d        = 1'b0;
    last_d       = last_q;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;
    if (clr) begin
      state_d      = IDLE;
      shadow_d     = '0;
      mask_d       = '0;
      dout_valid_d = 1'b0;
      cnt_clr      = 1'b1;
    end else if (state_q == STALL) begin
      if (dout_ready) begin
        dout_d       = shadow_q;
        dout_valid_d = 1'b1;
        mask_d       = '0;
        cnt_clr      = 1'b1;
        state_d      = IDLE;
      end
    end else if (accept) begin
      shadow_d = shadow_wr;
      mask_d   = mask_wr;
      dup_d    = mode_eff && mask_q[slot];
      if (mode_eff) begin
        last_d = slot;
      end else begin
        cnt_en = 1'b1;
      end
      if (&mask_wr) begin
        if (!dout_valid_q || dout_ready) begin
          dout_d       = shadow_wr;
          dout_valid_d = 1'b1;
          mask_d       = '0;
          cnt_clr      = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = STALL;
        end
      end else begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      shadow_q     <= '0;
      mask_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
      dup_q        <= 1'b0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      if (state_q == IDLE) begin
        mode_q <= sel_mode;
      end
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= (state_d != STALL);
      dup_q        <= dup_d;
      last_q       <= last_d;
    end
  end

  assign din_ready   = din_ready_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign dup         = dup_q;
  assign sel_cur     = mode_q ? last_q : cnt;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_demux18_deser.sv
// Directed table-driven bench for demux18_deser plus hand sequences for
// ext mode, duplicate writes and asynchronous reset mid-word.
module tb_demux18_deser;
  import demux18_pkg::*;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din, din_valid, din_ready;
  logic          sel_mode;
  logic [SW-1:0] sel_ext;
  logic          clr;
  logic [N-1:0]  dout;
  logic          dout_valid, dout_ready;
  logic [SW-1:0] sel_cur;
  logic          dup;
  dmx_state_t    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  demux18_deser #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .sel_mode    (sel_mode),
    .sel_ext     (sel_ext),
    .clr         (clr),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .sel_cur     (sel_cur),
    .dup         (dup),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic       d;
    logic       dr;
    logic       cl;
    logic       edv;
    logic [7:0] edout;
    logic       erdy;
    logic [1:0] est;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic dv, input logic d, input logic dr, input logic cl,
                     input logic edv, input logic [7:0] edout, input logic erdy,
                     input logic [1:0] est);
    vec_t v;
    v.dv = dv; v.d = d; v.dr = dr; v.cl = cl;
    v.edv = edv; v.edout = edout; v.erdy = erdy; v.est = est;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic d, input logic [SW-1:0] ext,
                      input logic dr, input logic cl);
    din_valid  = dv;
    din        = d;
    sel_ext    = ext;
    dout_ready = dr;
    clr        = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;
    int         dup_cnt;
    int         slots[9];
    int         bits[9];

    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; sel_mode = 1'b0;
    sel_ext = '0; clr = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_din_ready", din_ready, 1'b1);
    chk("rst_sel_cur", sel_cur, 3'd0);
    chk("rst_dup", dup, 1'b0);
    rst_n = 1'b1;

    // Auto word 0x4D with dout_ready=1: one-cycle valid pulse.
    w = 8'h4D;
    for (int i = 0; i < 7; i++) add(1, w[i], 1, 0, 0, 8'h00, 1, FILL);
    add(1, w[7], 1, 0, 1, 8'h4D, 1, IDLE);
    add(0, 0, 1, 0, 0, 8'h00, 1, IDLE);

    // clr after three bits drops the bit presented alongside it.
    w = 8'hA5;
    for (int i = 0; i < 3; i++) add(1, w[i], 1, 0, 0, 8'h00, 1, FILL);
    add(1, 1, 1, 1, 0, 8'h00, 1, IDLE);
    for (int i = 0; i < 7; i++) add(1, w[i], 1, 0, 0, 8'h00, 1, FILL);
    add(1, w[7], 1, 0, 1, 8'hA5, 1, IDLE);
    add(0, 0, 1, 0, 0, 8'h00, 1, IDLE);

    // Completion on the same edge as the consumer takes the previous word.
    w = 8'h3C;
    for (int i = 0; i < 7; i++) add(1, w[i], 1, 0, 0, 8'h00, 1, FILL);
    add(1, w[7], 1, 0, 1, 8'h3C, 1, IDLE);
    w = 8'hC3;
    for (int i = 0; i < 7; i++) add(1, w[i], 0, 0, 1, 8'h3C, 1, FILL);
    add(1, w[7], 1, 0, 1, 8'hC3, 1, IDLE);
    add(0, 0, 1, 0, 0, 8'h00, 1, IDLE);

    // Backpressure: second word completes into STALL, released by dout_ready.
    w = 8'h4D;
    for (int i = 0; i < 7; i++) add(1, w[i], 0, 0, 0, 8'h00, 1, FILL);
    add(1, w[7], 0, 0, 1, 8'h4D, 1, IDLE);
    for (int i = 0; i < 7; i++) add(1, 1, 0, 0, 1, 8'h4D, 1, FILL);
    add(1, 1, 0, 0, 1, 8'h4D, 0, STALL);
    add(1, 0, 0, 0, 1, 8'h4D, 0, STALL);
    add(0, 0, 1, 0, 1, 8'hFF, 1, IDLE);
    add(0, 0, 1, 0, 0, 8'h00, 1, IDLE);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].dv, tbl[i].d, '0, tbl[i].dr, tbl[i].cl);
      chk($sformatf("vec%0d_dout_valid", i), dout_valid, tbl[i].edv);
      chk($sformatf("vec%0d_din_ready", i), din_ready, tbl[i].erdy);
      chk($sformatf("vec%0d_state", i), dbg_state, tbl[i].est);
      chk($sformatf("vec%0d_dup", i), dup, 1'b0);
      if (tbl[i].edv) chk($sformatf("vec%0d_dout", i), dout, tbl[i].edout);
    end

    // Ext mode: slots 7..0, ones only at 7 and 0.
    sel_mode = 1'b1;
    step(0, 0, '0, 1, 0);
    dup_cnt = 0;
    for (int s = 7; s >= 0; s--) begin
      step(1, (s == 7 || s == 0), SW'(s), 1, 0);
      dup_cnt += int'(dup);
    end
    chk("ext1_dout", dout, 8'h81);
    chk("ext1_dout_valid", dout_valid, 1'b1);
    chk("ext1_sel_cur", sel_cur, 3'd0);
    chk("ext1_dup_count", dup_cnt, 0);

    // Ext mode with slot 3 written twice (1 then 0).
    slots = '{7, 6, 5, 4, 3, 3, 2, 1, 0};
    bits  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    dup_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      step(1, bits[k][0], SW'(slots[k]), 1, 0);
      dup_cnt += int'(dup);
      if (k == 5) chk("ext2_dup_pulse", dup, 1'b1);
      if (k == 7) begin
        chk("ext2_no_early_done", dout_valid, 1'b0);
        chk("ext2_sel_cur_last", sel_cur, 3'd1);
      end
    end
    chk("ext2_dout", dout, 8'h81);
    chk("ext2_dout_valid", dout_valid, 1'b1);
    chk("ext2_dup_count", dup_cnt, 1);
    sel_mode = 1'b0;
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);

    // Async reset three bits into an auto word.
    for (int i = 0; i < 3; i++) step(1, 1, '0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_dout_valid", dout_valid, 1'b0);
    chk("midrst_din_ready", din_ready, 1'b1);
    chk("midrst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    chk("midrst_held_dout_valid", dout_valid, 1'b0);
    chk("midrst_held_sel_cur", sel_cur, 3'd0);
    rst_n = 1'b1;
    w = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      step(1, w[i], '0, 1, 0);
      if (i == 6) chk("postrst_not_done", dout_valid, 1'b0);
    end
    chk("postrst_dout", dout, 8'h5A);
    chk("postrst_dout_valid", dout_valid, 1'b1);
    step(0, 0, '0, 1, 0);
    chk("postrst_consumed", dout_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
